// File: rtl/brams_portb_sequencer_if.sv
// Command, status and router-control bundle for the BRAM port-B sequencer.
// The sequencer takes the slave view; whoever issues commands takes the master view.
interface brams_portb_sequencer_if #(
   parameter int BRAM_AW = 10,
   parameter int BRAMS   = 8
);
   localparam int SW = $clog2(BRAMS);

   // command channel
   logic               cmd_valid;
   logic               cmd_ready;
   logic [SW-1:0]      cmd_src_a;
   logic [SW-1:0]      cmd_src_b;
   logic [SW-1:0]      cmd_dst;
   logic [BRAM_AW-1:0] cmd_base_a;
   logic [BRAM_AW-1:0] cmd_base_b;
   logic [BRAM_AW-1:0] cmd_base_c;
   logic [BRAM_AW:0]   cmd_len;
   logic               abort;

   // status
   logic               busy;
   logic               done;
   logic               err;

   // router / math unit control
   logic               math_in_valid;
   logic [BRAM_AW-1:0] math_adr_a;
   logic [BRAM_AW-1:0] math_adr_b;
   logic [BRAM_AW-1:0] math_adr_c;
   logic [BRAMS*2-1:0] adr_sel;
   logic               math_we;
   logic [SW-1:0]      we_sel;
   logic [SW-1:0]      dat_a_sel;
   logic [SW-1:0]      dat_b_sel;

   modport slave (
      input  cmd_valid, cmd_src_a, cmd_src_b, cmd_dst,
             cmd_base_a, cmd_base_b, cmd_base_c, cmd_len, abort,
      output cmd_ready, busy, done, err,
             math_in_valid, math_adr_a, math_adr_b, math_adr_c,
             adr_sel, math_we, we_sel, dat_a_sel, dat_b_sel
   );

   modport master (
      output cmd_valid, cmd_src_a, cmd_src_b, cmd_dst,
             cmd_base_a, cmd_base_b, cmd_base_c, cmd_len, abort,
      input  cmd_ready, busy, done, err,
             math_in_valid, math_adr_a, math_adr_b, math_adr_c,
             adr_sel, math_we, we_sel, dat_a_sel, dat_b_sel
   );
endinterface

// File: rtl/brams_portb_sequencer.sv
// Sequencer for the BRAM port-B router: reads two operand vectors, streams them
// to the math unit and writes the results back, timing each write with a
// fixed-latency valid shift register.
module brams_portb_sequencer #(
   parameter int BRAM_AW  = 10,
   parameter int BRAMS    = 8,
   parameter int MATH_LAT = 4
) (
   input logic                    clk,
   input logic                    rst_n,
   brams_portb_sequencer_if.slave bus
);
   localparam int SW = $clog2(BRAMS);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t             state_q, state_d;
   logic [MATH_LAT:0]  pipe_q, pipe_d;        // [0]=operands at math input, [MATH_LAT]=result ready
   logic [BRAM_AW:0]   rd_idx_q, rd_idx_d;
   logic [BRAM_AW:0]   len_q, len_d;
   logic [BRAM_AW-1:0] adr_a_q, adr_a_d;
   logic [BRAM_AW-1:0] adr_b_q, adr_b_d;
   logic [BRAM_AW-1:0] adr_c_q, adr_c_d;
   logic [BRAM_AW-1:0] wr_next_q, wr_next_d;  // address the next result write will use
   logic [SW-1:0]      src_a_q, src_a_d;
   logic [SW-1:0]      src_b_q, src_b_d;
   logic [SW-1:0]      dst_q, dst_d;
   logic [BRAMS*2-1:0] adr_sel_q, adr_sel_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               cmd_ready_q, cmd_ready_d;
   logic               busy_q, busy_d;
   logic               cmd_reject;

   // A destination that is also a source would collide on the port; one BRAM
   // serving both operands can only do so when both streams use the same address.
   assign cmd_reject = (bus.cmd_dst == bus.cmd_src_a) || (bus.cmd_dst == bus.cmd_src_b) ||
                       ((bus.cmd_src_a == bus.cmd_src_b) && (bus.cmd_base_a != bus.cmd_base_b));

   // Next-state, tracker and router-control computation.
   always_comb begin
      state_d   = state_q;
      pipe_d    = pipe_q;
      rd_idx_d  = rd_idx_q;
      len_d     = len_q;
      adr_a_d   = adr_a_q;
      adr_b_d   = adr_b_q;
      adr_c_d   = adr_c_q;
      wr_next_d = wr_next_q;
      src_a_d   = src_a_q;
      src_b_d   = src_b_q;
      dst_d     = dst_q;
      done_d    = 1'b0;
      err_d     = 1'b0;

      case (state_q)
         IDLE: begin
            pipe_d = '0;
            if (bus.cmd_valid) begin
               if (cmd_reject) begin
                  err_d = 1'b1;
               end else if (bus.cmd_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d   = READ;
                  len_d     = bus.cmd_len;
                  rd_idx_d  = '0;
                  adr_a_d   = bus.cmd_base_a;
                  adr_b_d   = bus.cmd_base_b;
                  wr_next_d = bus.cmd_base_c;
                  src_a_d   = bus.cmd_src_a;
                  src_b_d   = bus.cmd_src_b;
                  dst_d     = bus.cmd_dst;
               end
            end
         end
         READ: begin
            pipe_d = {pipe_q[MATH_LAT-1:0], 1'b1};
            if (rd_idx_q == len_q - 1'b1) begin
               state_d = DRAIN;
            end else begin
               rd_idx_d = rd_idx_q + 1'b1;
               adr_a_d  = adr_a_q + 1'b1;
               adr_b_d  = adr_b_q + 1'b1;
            end
         end
         DRAIN: begin
            pipe_d = {pipe_q[MATH_LAT-1:0], 1'b0};
            // Only the tail bit left means this cycle carries the final write.
            if (pipe_q[MATH_LAT-1:0] == '0) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (bus.abort && (state_q != IDLE)) begin
         state_d = IDLE;
         pipe_d  = '0;
         done_d  = 1'b0;
      end

      if (pipe_d[MATH_LAT]) begin
         adr_c_d   = wr_next_q;
         wr_next_d = wr_next_q + 1'b1;
      end

      // Source a is applied last so a shared source BRAM ends up with code 0.
      adr_sel_d = '1;
      if (state_d == READ) begin
         adr_sel_d[2*int'(src_b_d) +: 2] = 2'd1;
         adr_sel_d[2*int'(src_a_d) +: 2] = 2'd0;
      end
      if (pipe_d[MATH_LAT]) begin
         adr_sel_d[2*int'(dst_d) +: 2] = 2'd2;
      end

      cmd_ready_d = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pipe_q      <= '0;
         rd_idx_q    <= '0;
         len_q       <= '0;
         adr_a_q     <= '0;
         adr_b_q     <= '0;
         adr_c_q     <= '0;
         wr_next_q   <= '0;
         src_a_q     <= '0;
         src_b_q     <= '0;
         dst_q       <= '0;
         adr_sel_q   <= '1;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pipe_q      <= pipe_d;
         rd_idx_q    <= rd_idx_d;
         len_q       <= len_d;
         adr_a_q     <= adr_a_d;
         adr_b_q     <= adr_b_d;
         adr_c_q     <= adr_c_d;
         wr_next_q   <= wr_next_d;
         src_a_q     <= src_a_d;
         src_b_q     <= src_b_d;
         dst_q       <= dst_d;
         adr_sel_q   <= adr_sel_d;
         done_q      <= done_d;
         err_q       <= err_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.cmd_ready     = cmd_ready_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.err           = err_q;
   assign bus.math_in_valid = pipe_q[0];
   assign bus.math_we       = pipe_q[MATH_LAT];
   assign bus.math_adr_a    = adr_a_q;
   assign bus.math_adr_b    = adr_b_q;
   assign bus.math_adr_c    = adr_c_q;
   assign bus.adr_sel       = adr_sel_q;
   assign bus.we_sel        = dst_q;
   assign bus.dat_a_sel     = src_a_q;
   assign bus.dat_b_sel     = src_b_q;
endmodule

// File: tb/tb_brams_portb_sequencer.sv
// Directed testbench for brams_portb_sequencer (BRAM_AW=10, BRAMS=8, MATH_LAT=4).
// Inputs change and outputs are sampled on the falling edge; "cycle c" below
// means c cycles after the accepting cycle T.
module tb_brams_portb_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   brams_portb_sequencer_if #(.BRAM_AW(10), .BRAMS(8)) bus ();

   brams_portb_sequencer #(.BRAM_AW(10), .BRAMS(8), .MATH_LAT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [1:0] sel_of(input int j);
      return bus.adr_sel[2*j +: 2];
   endfunction

   // Offer one command for one cycle; returns at the falling edge of cycle T+1.
   task automatic issue(input logic [2:0] sa, input logic [2:0] sb, input logic [2:0] d,
                        input logic [9:0] ba, input logic [9:0] bb, input logic [9:0] bc,
                        input logic [10:0] len);
      bus.cmd_src_a  = sa;
      bus.cmd_src_b  = sb;
      bus.cmd_dst    = d;
      bus.cmd_base_a = ba;
      bus.cmd_base_b = bb;
      bus.cmd_base_c = bc;
      bus.cmd_len    = len;
      bus.cmd_valid  = 1'b1;
      $display("cmd: src_a=%0d src_b=%0d dst=%0d base_a=%h base_b=%h base_c=%h len=%0d",
               sa, sb, d, ba, bb, bc, len);
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if ({bus.cmd_ready, bus.busy, bus.done, bus.err, bus.math_in_valid, bus.math_we} !== 6'b100000)
         begin miscompares++;
         $display("FAIL reset_flags: got %b want 100000",
                  {bus.cmd_ready, bus.busy, bus.done, bus.err, bus.math_in_valid, bus.math_we}); end
      vectors++;
      if (bus.adr_sel !== 16'hFFFF || {bus.math_adr_a, bus.math_adr_b, bus.math_adr_c} !== 30'd0 ||
          {bus.we_sel, bus.dat_a_sel, bus.dat_b_sel} !== 9'd0)
         begin miscompares++;
         $display("FAIL reset_bus: adr_sel=%h adr_a=%h adr_b=%h adr_c=%h sels=%b, want FFFF/0/0/0/0",
                  bus.adr_sel, bus.math_adr_a, bus.math_adr_b, bus.math_adr_c,
                  {bus.we_sel, bus.dat_a_sel, bus.dat_b_sel}); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [3:0] exp_f;
      issue(3'd1, 3'd2, 3'd5, 10'h010, 10'h020, 10'h030, 11'd3);
      for (int c = 1; c <= 10; c++) begin
         // {busy, done, math_in_valid, math_we}
         exp_f = {(c >= 1 && c <= 8), (c == 9), (c >= 2 && c <= 4), (c >= 6 && c <= 8)};
         vectors++;
         if ({bus.busy, bus.done, bus.math_in_valid, bus.math_we} !== exp_f) begin
            miscompares++;
            $display("FAIL basic_flags c=%0d: got %b want %b", c,
                     {bus.busy, bus.done, bus.math_in_valid, bus.math_we}, exp_f);
         end
         if (c <= 3) begin
            vectors++;
            if (bus.math_adr_a !== 10'(16 + c - 1) || bus.math_adr_b !== 10'(32 + c - 1) ||
                sel_of(1) !== 2'd0 || sel_of(2) !== 2'd1) begin
               miscompares++;
               $display("FAIL basic_read c=%0d: adr_a=%h adr_b=%h sel1=%0d sel2=%0d want %h %h 0 1",
                        c, bus.math_adr_a, bus.math_adr_b, sel_of(1), sel_of(2),
                        10'(16 + c - 1), 10'(32 + c - 1));
            end
         end
         if (c >= 6 && c <= 8) begin
            vectors++;
            if (bus.math_adr_c !== 10'(48 + c - 6) || sel_of(5) !== 2'd2 || bus.we_sel !== 3'd5) begin
               miscompares++;
               $display("FAIL basic_write c=%0d: adr_c=%h sel5=%0d we_sel=%0d want %h 2 5",
                        c, bus.math_adr_c, sel_of(5), bus.we_sel, 10'(48 + c - 6));
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_wrap();
      logic [9:0] seq [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
      issue(3'd1, 3'd2, 3'd5, 10'h3FE, 10'h100, 10'h3FE, 11'd4);
      for (int c = 1; c <= 10; c++) begin
         if (c <= 4) begin
            vectors++;
            if (bus.math_adr_a !== seq[c-1]) begin
               miscompares++;
               $display("FAIL wrap_adr_a c=%0d: got %h want %h", c, bus.math_adr_a, seq[c-1]);
            end
         end
         if (c >= 6 && c <= 9) begin
            vectors++;
            if (bus.math_we !== 1'b1 || bus.math_adr_c !== seq[c-6]) begin
               miscompares++;
               $display("FAIL wrap_adr_c c=%0d: we=%b adr_c=%h want 1 %h", c, bus.math_we,
                        bus.math_adr_c, seq[c-6]);
            end
         end
         if (c == 10) begin
            vectors++;
            if (bus.done !== 1'b1 || bus.math_we !== 1'b0) begin
               miscompares++;
               $display("FAIL wrap_done: done=%b we=%b want 1 0", bus.done, bus.math_we);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reject();
      // destination equals source a
      issue(3'd2, 3'd3, 3'd2, 10'h000, 10'h000, 10'h000, 11'd5);
      for (int c = 1; c <= 8; c++) begin
         vectors++;
         if ({bus.err, bus.cmd_ready, bus.busy, bus.math_in_valid, bus.math_we, bus.done} !==
             {(c == 1), 5'b10000}) begin
            miscompares++;
            $display("FAIL reject_dst c=%0d: err/rdy/busy/miv/we/done=%b want %b", c,
                     {bus.err, bus.cmd_ready, bus.busy, bus.math_in_valid, bus.math_we, bus.done},
                     {(c == 1), 5'b10000});
         end
         @(negedge clk);
      end
      // shared source with differing bases
      issue(3'd3, 3'd3, 3'd6, 10'h040, 10'h041, 10'h000, 11'd2);
      vectors++;
      if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reject_bases: err=%b busy=%b want 1 0", bus.err, bus.busy);
      end
      @(negedge clk);
   endtask

   task automatic test_same_src();
      issue(3'd3, 3'd3, 3'd6, 10'h040, 10'h040, 10'h070, 11'd2);
      for (int c = 1; c <= 8; c++) begin
         if (c <= 2) begin
            vectors++;
            if (sel_of(3) !== 2'd0 || bus.dat_a_sel !== 3'd3 || bus.dat_b_sel !== 3'd3 ||
                bus.err !== 1'b0) begin
               miscompares++;
               $display("FAIL same_src c=%0d: sel3=%0d dat_a=%0d dat_b=%0d err=%b want 0 3 3 0",
                        c, sel_of(3), bus.dat_a_sel, bus.dat_b_sel, bus.err);
            end
         end
         vectors++;
         if ({bus.math_in_valid, bus.math_we, bus.done} !==
             {(c == 2 || c == 3), (c == 6 || c == 7), (c == 8)}) begin
            miscompares++;
            $display("FAIL same_src_timing c=%0d: miv/we/done=%b want %b", c,
                     {bus.math_in_valid, bus.math_we, bus.done},
                     {(c == 2 || c == 3), (c == 6 || c == 7), (c == 8)});
         end
         @(negedge clk);
      end
   endtask

   task automatic test_len0();
      issue(3'd0, 3'd1, 3'd2, 10'h000, 10'h000, 10'h000, 11'd0);
      for (int c = 1; c <= 6; c++) begin
         vectors++;
         if ({bus.done, bus.busy, bus.math_in_valid, bus.math_we, bus.err, bus.cmd_ready} !==
             {(c == 1), 5'b00001}) begin
            miscompares++;
            $display("FAIL len0 c=%0d: done/busy/miv/we/err/rdy=%b want %b", c,
                     {bus.done, bus.busy, bus.math_in_valid, bus.math_we, bus.err, bus.cmd_ready},
                     {(c == 1), 5'b00001});
         end
         @(negedge clk);
      end
   endtask

   task automatic test_abort();
      int writes = 0;
      issue(3'd1, 3'd2, 3'd5, 10'h000, 10'h100, 10'h200, 11'd8);
      for (int c = 1; c <= 9; c++) begin
         if (bus.math_we === 1'b1) writes++;
         @(negedge clk);
      end
      vectors++;
      if (writes != 4) begin
         miscompares++;
         $display("FAIL abort_writes: got %0d writes before T+10, want 4", writes);
      end
      bus.abort = 1'b1;            // sampled at the end of cycle T+10
      @(posedge clk);
      @(negedge clk);
      bus.abort = 1'b0;
      vectors++;
      if (bus.math_we !== 1'b0 || bus.adr_sel !== 16'hFFFF || bus.busy !== 1'b0 ||
          bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_t11: we=%b adr_sel=%h busy=%b done=%b rdy=%b want 0 FFFF 0 0 1",
                  bus.math_we, bus.adr_sel, bus.busy, bus.done, bus.cmd_ready);
      end
      for (int c = 12; c <= 16; c++) begin
         @(negedge clk);
         vectors++;
         if (bus.math_we !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_quiet c=%0d: we=%b done=%b err=%b want 0 0 0", c,
                     bus.math_we, bus.done, bus.err);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      issue(3'd1, 3'd2, 3'd5, 10'h055, 10'h066, 10'h077, 11'd6);
      @(negedge clk);              // cycle 2, mid-READ
      vectors++;
      if (bus.busy !== 1'b1 || bus.math_adr_a !== 10'h056) begin
         miscompares++;
         $display("FAIL areset_pre: busy=%b adr_a=%h want 1 056", bus.busy, bus.math_adr_a);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({bus.cmd_ready, bus.busy, bus.done, bus.err, bus.math_in_valid, bus.math_we} !== 6'b100000 ||
          bus.adr_sel !== 16'hFFFF || {bus.math_adr_a, bus.math_adr_b, bus.math_adr_c} !== 30'd0 ||
          {bus.we_sel, bus.dat_a_sel, bus.dat_b_sel} !== 9'd0) begin
         miscompares++;
         $display("FAIL areset_now: flags=%b adr_sel=%h adr_a=%h sels=%b want 100000 FFFF 0 0",
                  {bus.cmd_ready, bus.busy, bus.done, bus.err, bus.math_in_valid, bus.math_we},
                  bus.adr_sel, bus.math_adr_a, {bus.we_sel, bus.dat_a_sel, bus.dat_b_sel});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(3'd4, 3'd0, 3'd7, 10'h200, 10'h000, 10'h300, 11'd1);
      for (int c = 1; c <= 7; c++) begin
         if (c == 1) begin
            vectors++;
            if (bus.math_adr_a !== 10'h200 || sel_of(4) !== 2'd0 || sel_of(0) !== 2'd1) begin
               miscompares++;
               $display("FAIL areset_read: adr_a=%h sel4=%0d sel0=%0d want 200 0 1",
                        bus.math_adr_a, sel_of(4), sel_of(0));
            end
         end
         vectors++;
         if ({bus.math_we, bus.done} !== {(c == 6), (c == 7)} ||
             (c == 6 && (bus.math_adr_c !== 10'h300 || sel_of(7) !== 2'd2))) begin
            miscompares++;
            $display("FAIL areset_run c=%0d: we=%b done=%b adr_c=%h sel7=%0d", c,
                     bus.math_we, bus.done, bus.math_adr_c, sel_of(7));
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      issue(3'd0, 3'd1, 3'd2, 10'h000, 10'h010, 10'h020, 11'd2);
      for (int c = 1; c < 8; c++) @(negedge clk);
      vectors++;
      if (bus.done !== 1'b1 || bus.cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_first_done: done=%b rdy=%b want 1 1", bus.done, bus.cmd_ready);
      end
      // offered in the done cycle
      issue(3'd6, 3'd5, 3'd3, 10'h123, 10'h0AA, 10'h1F0, 11'd1);
      for (int c = 1; c <= 7; c++) begin
         if (c == 1) begin
            vectors++;
            if (bus.busy !== 1'b1 || bus.math_adr_a !== 10'h123 || bus.math_adr_b !== 10'h0AA ||
                bus.dat_a_sel !== 3'd6 || bus.dat_b_sel !== 3'd5) begin
               miscompares++;
               $display("FAIL b2b_accept: busy=%b adr_a=%h adr_b=%h dat_a=%0d dat_b=%0d",
                        bus.busy, bus.math_adr_a, bus.math_adr_b, bus.dat_a_sel, bus.dat_b_sel);
            end
         end
         vectors++;
         if ({bus.math_we, bus.done} !== {(c == 6), (c == 7)} ||
             (c == 6 && bus.math_adr_c !== 10'h1F0)) begin
            miscompares++;
            $display("FAIL b2b_second c=%0d: we=%b done=%b adr_c=%h", c,
                     bus.math_we, bus.done, bus.math_adr_c);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      bus.cmd_valid  = 1'b0;
      bus.cmd_src_a  = '0;
      bus.cmd_src_b  = '0;
      bus.cmd_dst    = '0;
      bus.cmd_base_a = '0;
      bus.cmd_base_b = '0;
      bus.cmd_base_c = '0;
      bus.cmd_len    = '0;
      bus.abort      = 1'b0;
      test_reset();
      test_basic();
      test_wrap();
      test_reject();
      test_same_src();
      test_len0();
      test_abort();
      test_async_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
